// File: rtl/writeback_arbiter.sv
// Six-requester, two-port writeback arbiter. Round-robin by default; define
// WB_ARB_AGE_PRIORITY_EN to pick port0 by ROB age (oldest first).
module writeback_arbiter (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic [5:0]       next_retire_inst_id,
    input  logic [5:0]       req_valid,
    input  logic [5:0][5:0]  req_rob_id,
    input  logic [5:0][5:0]  req_rd_phy,
    input  logic [5:0][31:0] req_rd_data,
    output logic [5:0]       req_allowin,
    output logic [1:0]       wb_valid,
    output logic [1:0][5:0]  wb_rob_id,
    output logic [1:0][5:0]  wb_rd_phy,
    output logic [1:0][31:0] wb_rd_data
);

    logic [2:0]       r_ptr;
    logic [1:0]       r_wb_valid;
    logic [1:0][5:0]  r_wb_rob_id;
    logic [1:0][5:0]  r_wb_rd_phy;
    logic [1:0][31:0] r_wb_rd_data;

    logic       w_g0_vld;
    logic [2:0] w_g0_idx;
    logic       w_g1_vld;
    logic [2:0] w_g1_idx;
    logic [2:0] w_idx1;
    logic [2:0] w_ptr_nxt;
    logic [5:0] w_allow;

    function automatic logic [2:0] wrap6(input logic [3:0] v);
        if (v >= 4'd6) return 3'(v - 4'd6);
        return v[2:0];
    endfunction

`ifdef WB_ARB_AGE_PRIORITY_EN
    logic [5:0] w_age_cur;
    logic [5:0] w_age_best;

    // Smallest distance from the ROB head wins; strict compare keeps ties on the lowest index.
    always_comb begin
        w_g0_vld   = 1'b0;
        w_g0_idx   = '0;
        w_age_cur  = '0;
        w_age_best = '0;
        for (int i = 0; i < 6; i++) begin
            w_age_cur = req_rob_id[i] - next_retire_inst_id;
            if (req_valid[i] && (!w_g0_vld || w_age_cur < w_age_best)) begin
                w_g0_vld   = 1'b1;
                w_g0_idx   = 3'(i);
                w_age_best = w_age_cur;
            end
        end
    end
`else
    logic [2:0] w_idx0;
    logic       w_unused_retire;

    assign w_unused_retire = ^next_retire_inst_id;

    always_comb begin
        w_g0_vld = 1'b0;
        w_g0_idx = '0;
        w_idx0   = '0;
        for (int k = 0; k < 6; k++) begin
            w_idx0 = wrap6({1'b0, r_ptr} + 4'(k));
            if (!w_g0_vld && req_valid[w_idx0]) begin
                w_g0_vld = 1'b1;
                w_g0_idx = w_idx0;
            end
        end
    end
`endif

    // Port1 scans from the pointer skipping the port0 winner; in round-robin mode
    // this lands on the next valid requester after the port0 winner.
    always_comb begin
        w_g1_vld = 1'b0;
        w_g1_idx = '0;
        w_idx1   = '0;
        for (int k = 0; k < 6; k++) begin
            w_idx1 = wrap6({1'b0, r_ptr} + 4'(k));
            if (!w_g1_vld && req_valid[w_idx1] && !(w_g0_vld && w_idx1 == w_g0_idx)) begin
                w_g1_vld = 1'b1;
                w_g1_idx = w_idx1;
            end
        end
    end

    always_comb begin
        if (w_g1_vld)      w_ptr_nxt = wrap6({1'b0, w_g1_idx} + 4'd1);
        else if (w_g0_vld) w_ptr_nxt = wrap6({1'b0, w_g0_idx} + 4'd1);
        else               w_ptr_nxt = r_ptr;
    end

    always_comb begin
        w_allow = '0;
        if (rst) begin
            w_allow = '0;
        end else if (flush) begin
            w_allow = req_valid;
        end else begin
            if (w_g0_vld) w_allow[w_g0_idx] = 1'b1;
            if (w_g1_vld) w_allow[w_g1_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr        <= '0;
            r_wb_valid   <= '0;
            r_wb_rob_id  <= '0;
            r_wb_rd_phy  <= '0;
            r_wb_rd_data <= '0;
        end else if (flush) begin
            r_wb_valid <= '0;
        end else begin
            r_wb_valid <= {w_g1_vld, w_g0_vld};
            r_ptr      <= w_ptr_nxt;
            if (w_g0_vld) begin
                r_wb_rob_id[0]  <= req_rob_id[w_g0_idx];
                r_wb_rd_phy[0]  <= req_rd_phy[w_g0_idx];
                r_wb_rd_data[0] <= req_rd_data[w_g0_idx];
            end
            if (w_g1_vld) begin
                r_wb_rob_id[1]  <= req_rob_id[w_g1_idx];
                r_wb_rd_phy[1]  <= req_rd_phy[w_g1_idx];
                r_wb_rd_data[1] <= req_rd_data[w_g1_idx];
            end
        end
    end

    assign req_allowin = w_allow;
    assign wb_valid    = r_wb_valid;
    assign wb_rob_id   = r_wb_rob_id;
    assign wb_rd_phy   = r_wb_rd_phy;
    assign wb_rd_data  = r_wb_rd_data;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Randomized self-checking bench for writeback_arbiter against a queue-based
// reference model; follows WB_ARB_AGE_PRIORITY_EN to pick the expected policy.
module tb_writeback_arbiter;

    logic             clk;
    logic             rst;
    logic             flush;
    logic [5:0]       next_retire_inst_id;
    logic [5:0]       req_valid;
    logic [5:0][5:0]  req_rob_id;
    logic [5:0][5:0]  req_rd_phy;
    logic [5:0][31:0] req_rd_data;
    logic [5:0]       req_allowin;
    logic [1:0]       wb_valid;
    logic [1:0][5:0]  wb_rob_id;
    logic [1:0][5:0]  wb_rd_phy;
    logic [1:0][31:0] wb_rd_data;

    writeback_arbiter dut (
        .clk                 (clk),
        .rst                 (rst),
        .flush               (flush),
        .next_retire_inst_id (next_retire_inst_id),
        .req_valid           (req_valid),
        .req_rob_id          (req_rob_id),
        .req_rd_phy          (req_rd_phy),
        .req_rd_data         (req_rd_data),
        .req_allowin         (req_allowin),
        .wb_valid            (wb_valid),
        .wb_rob_id           (wb_rob_id),
        .wb_rd_phy           (wb_rd_phy),
        .wb_rd_data          (wb_rd_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    int         m_p;
    logic [5:0] e_allow;
    int         e_g0;
    int         e_g1;
    logic [5:0] obs_allow;
    int         wait_cnt [6];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [43:0] req_pay(input int i);
        return {req_rob_id[i], req_rd_phy[i], req_rd_data[i]};
    endfunction

    // Reference: list valid requesters in circular order from p, take winners off the list.
    task automatic model_grant();
        int order[$];
        int best;
        int best_age;
        int age;
        e_allow = '0;
        e_g0    = -1;
        e_g1    = -1;
        if (rst) return;
        if (flush) begin
            e_allow = req_valid;
            return;
        end
        for (int k = 0; k < 6; k++)
            if (req_valid[(m_p + k) % 6]) order.push_back((m_p + k) % 6);
        if (order.size() == 0) return;
`ifdef WB_ARB_AGE_PRIORITY_EN
        best = -1;
        best_age = 0;
        for (int i = 0; i < 6; i++) begin
            age = (int'(req_rob_id[i]) - int'(next_retire_inst_id) + 64) % 64;
            if (req_valid[i] && (best < 0 || age < best_age)) begin
                best = i;
                best_age = age;
            end
        end
        e_g0 = best;
`else
        best = 0;
        best_age = 0;
        age = 0;
        e_g0 = order[0];
`endif
        foreach (order[j]) begin
            if (e_g1 < 0 && order[j] != e_g0) e_g1 = order[j];
        end
        e_allow[e_g0] = 1'b1;
        if (e_g1 >= 0) e_allow[e_g1] = 1'b1;
    endtask

    task automatic step();
        logic [1:0]  ex_v;
        logic [43:0] ex_p0;
        logic [43:0] ex_p1;
        logic        was_rst;
        int          worst;
        #1;
        model_grant();
        obs_allow = req_allowin;
        chk("allowin", {58'd0, req_allowin}, {58'd0, e_allow});
        was_rst = rst;
        ex_v  = 2'b00;
        ex_p0 = '0;
        ex_p1 = '0;
        if (rst) begin
            m_p = 0;
        end else if (!flush && e_g0 >= 0) begin
            ex_v[0] = 1'b1;
            ex_p0   = req_pay(e_g0);
            if (e_g1 >= 0) begin
                ex_v[1] = 1'b1;
                ex_p1   = req_pay(e_g1);
                m_p     = (e_g1 + 1) % 6;
            end else begin
                m_p = (e_g0 + 1) % 6;
            end
        end
        worst = 0;
        for (int i = 0; i < 6; i++) begin
            if (rst || !req_valid[i] || obs_allow[i]) wait_cnt[i] = 0;
            else wait_cnt[i]++;
            if (wait_cnt[i] > worst) worst = wait_cnt[i];
        end
        @(posedge clk);
        #1;
        chk("wb_valid", {62'd0, wb_valid}, {62'd0, ex_v});
        if (was_rst) begin
            chk("rst_pay0", {20'd0, wb_rob_id[0], wb_rd_phy[0], wb_rd_data[0]}, 64'd0);
            chk("rst_pay1", {20'd0, wb_rob_id[1], wb_rd_phy[1], wb_rd_data[1]}, 64'd0);
        end else begin
            if (ex_v[0]) chk("wb_pay0", {20'd0, wb_rob_id[0], wb_rd_phy[0], wb_rd_data[0]}, {20'd0, ex_p0});
            if (ex_v[1]) chk("wb_pay1", {20'd0, wb_rob_id[1], wb_rd_phy[1], wb_rd_data[1]}, {20'd0, ex_p1});
        end
`ifndef WB_ARB_AGE_PRIORITY_EN
        chk("starve", {63'd0, worst > 2}, 64'd0);
`endif
    endtask

    task automatic rand_payload(input int i);
        req_rob_id[i]  = 6'($urandom);
        req_rd_phy[i]  = 6'($urandom);
        req_rd_data[i] = $urandom;
    endtask

    initial begin
        m_p = 0;
        for (int i = 0; i < 6; i++) begin
            wait_cnt[i] = 0;
            rand_payload(i);
        end
        next_retire_inst_id = '0;
        obs_allow = '0;

        // Reset and flush together: reset wins, nothing accepted.
        rst = 1'b1;
        flush = 1'b1;
        req_valid = 6'b000100;
        step();
        chk("s34_allow", {58'd0, obs_allow}, 64'd0);
        rst = 1'b0;
        flush = 1'b0;

`ifdef WB_ARB_AGE_PRIORITY_EN
        next_retire_inst_id = 6'd62;
        req_rob_id[0] = 6'd5;
        req_rob_id[3] = 6'd63;
        req_valid = 6'b001001;
        step();
        chk("s35_allow", {58'd0, obs_allow}, 64'h09);
        chk("s35_port0", {58'd0, wb_rob_id[0]}, 64'd63);
        chk("s35_port1", {58'd0, wb_rob_id[1]}, 64'd5);
`else
        req_valid = 6'b000101;
        step();
        chk("s31_allow", {58'd0, obs_allow}, 64'h05);
        chk("s31_wbv", {62'd0, wb_valid}, 64'h3);
        chk("s31_port0", {20'd0, wb_rob_id[0], wb_rd_phy[0], wb_rd_data[0]}, {20'd0, req_pay(0)});
        chk("s31_port1", {20'd0, wb_rob_id[1], wb_rd_phy[1], wb_rd_data[1]}, {20'd0, req_pay(2)});
        req_valid = 6'b111111;
        step();
        chk("s31_p3", {58'd0, obs_allow}, 64'h18);

        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("s32_c0", {58'd0, obs_allow}, 64'h03);
        step();
        chk("s32_c1", {58'd0, obs_allow}, 64'h0c);
        step();
        chk("s32_c2", {58'd0, obs_allow}, 64'h30);
        step();
        chk("s32_c3", {58'd0, obs_allow}, 64'h03);

        flush = 1'b1;
        step();
        chk("s33_allow", {58'd0, obs_allow}, 64'h3f);
        chk("s33_wbv", {62'd0, wb_valid}, 64'h0);
        flush = 1'b0;
        step();
        chk("s33_p", {58'd0, obs_allow}, 64'h0c);

        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 6'b010000;
        step();
        step();
        chk("s36_allow", {58'd0, obs_allow}, 64'h10);
        chk("s36_wbv", {62'd0, wb_valid}, 64'h1);
        req_valid = 6'b111111;
        step();
        chk("s36_p5", {58'd0, obs_allow}, 64'h21);
`endif

        // Random traffic; ungranted requesters hold valid and payload.
        for (int c = 0; c < 400; c++) begin
            rst   = ($urandom_range(0, 99) < 2);
            flush = !rst && ($urandom_range(0, 99) < 5);
            next_retire_inst_id = 6'($urandom);
            for (int i = 0; i < 6; i++) begin
                if (!req_valid[i] || obs_allow[i]) begin
                    req_valid[i] = ($urandom_range(0, 99) < 60);
                    rand_payload(i);
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
